hilo_div_unit: RTL and testbench
================================

# hilo_div_unit

HI/LO register file with an iterative 32-bit radix-2 divider, sitting in the execute stage of the five-stage MIPS pipeline. It consumes the HI/LO control produced by the pipeline controller:
- the write-back HI/LO write strobe and select (mthi/mtlo);
- 64-bit product writes from the multiplier;
- div/divu requests from execute.

It stalls the pipeline while a division is in flight.

## Interface
- `DIV_W`, 32: operand and HI/LO width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-low reset.
- `div_start_i` in 1: execute stage holds div/divu.
- `div_signed_i` in 1: 1 = div, 0 = divu; sampled with start.
- `div_a_i`, `div_b_i` in DIV_W: dividend and divisor; sampled with start.
- `div_cancel_i` in 1: flush of execute; aborts the division.
- `hilo_we_i` in 1: write-back mthi/mtlo strobe.
- `hilo_sel_i` in 1: 1 = HI, 0 = LO.
- `hilo_wdata_i` in DIV_W: mthi/mtlo data.
- `mul_we_i` in 1: product write.
- `mul_hi_i`, `mul_lo_i` in DIV_W: product halves.
- `stall_o` out 1: combinational pipeline stall.
- `div_done_o` out 1: high for one cycle in DONE.
- `hi_o`, `lo_o` out DIV_W: HI/LO contents.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
- **IDLE**
  - `div_start_i` & !`div_cancel_i`: latch |a|, |b|, sign flags and raw a; clear the iteration counter; go to RUN.
  - Otherwise stay in IDLE.
- **RUN**: one restoring step per cycle.
  - Shift the {rem, quot} pair left by one.
  - Trial-subtract |b|; set the quotient bit if the result is non-negative.
  - After 32 steps (counter 31 → wrap), go to FIX.
- **FIX**: apply the sign rules; write HI = remainder, LO = quotient at the FIX→DONE edge.
- **DONE**: `div_done_o` = 1; go to IDLE on the next edge.
- `div_start_i` is ignored in RUN, FIX and DONE, because the same instruction is still held in execute.
- Sign rules (signed only):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives LO = 0x80000000, HI = 0.
- Divide by zero (b == 0, either mode): the iteration runs normally but FIX forces LO = 0xFFFFFFFF and HI = raw a.
- Cancel: `div_cancel_i` in RUN or FIX goes to IDLE on the next edge with no HI/LO write. Cancel in DONE has no effect.
- HI/LO write priority in one cycle, highest first:
  1. Divider FIX→DONE write.
  2. `mul_we_i`, which writes both HI and LO.
  3. `hilo_we_i`, which writes only the selected register.
- The reason for this order: the write-back stage holds an older instruction, so the divider result must win.
- `stall_o` = (IDLE & `div_start_i` & !`div_cancel_i`) | RUN | FIX.

## Timing
- Reset: state = IDLE, `hi_o` = `lo_o` = 0, `div_done_o` = 0, counter = 0. Reset mid-division aborts without a write.
- Latency, with start seen in IDLE at cycle 0:
  - RUN occupies cycles 1–32.
  - FIX is cycle 33.
  - DONE is cycle 34, and the new HI/LO is visible on `hi_o`/`lo_o` in cycle 34.
  - `stall_o` is high in cycles 0–33 (34 cycles) and low in cycle 34.
- mthi/mtlo and product writes are visible the cycle after the strobe.
- Back-to-back divisions: the next start is accepted in the IDLE cycle following DONE.

## Configuration
- `HILO_BYPASS_EN`
  - Defined: `hi_o`/`lo_o` are write-through. The same-cycle write value is forwarded combinationally using the same priority as the register update.
  - Undefined: `hi_o`/`lo_o` are driven directly from the registers. The pipeline's forwarding logic covers the one-cycle gap.

## Structure
- `hilo_pkg` holds:
  - the state enum (IDLE/RUN/FIX/DONE);
  - `DIV_ITER` = 32;
  - `DIV_ZERO_QUOT` = 32'hFFFF_FFFF.
- Sub-module `div_core` is the datapath:
  - operand magnitudes, {rem, quot} shift register, trial subtractor and sign fix-up;
  - controlled by load/step/fix strobes from the top-level FSM.
- The top level holds the FSM, the counter, the HI/LO registers and the write-priority mux.

## Test plan
1. divu 100 / 7 → `stall_o` high 34 cycles; cycle 34: LO = 14, HI = 2, `div_done_o` pulse.
2. div -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Also div 0x80000000 / -1 → LO = 0x80000000, HI = 0.
3. divu 0x12345678 / 0 → LO = 0xFFFFFFFF, HI = 0x12345678; latency unchanged at 34.
4. Start div, assert `div_cancel_i` at cycle 10 → IDLE at cycle 11, `stall_o` low, HI/LO unchanged, no done pulse.
5. `hilo_we_i` (HI, 0xAAAA0000) on the FIX→DONE edge → HI = divider remainder. Next, mtlo 0x55 alone → LO = 0x55 the following cycle. Then `mul_we_i` together with `hilo_we_i` → product wins on both registers.
6. Pull `rst` low during RUN cycle 20 → IDLE, HI = LO = 0, `stall_o` = 0. A new start after reset completes normally.

Source files
------------

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared divider FSM states and constants for hilo_div_unit.
package hilo_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} divState_t;
  localparam int DIV_ITER = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_core.sv
// div_core: restoring radix-2 divider datapath driven by load/step/fix strobes from the FSM.
module div_core
  import hilo_pkg::*;
#(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic             signedOp,
  input  logic [DIV_W-1:0] a,
  input  logic [DIV_W-1:0] b,
  output logic [DIV_W-1:0] hiRes,
  output logic [DIV_W-1:0] loRes
);
  logic [DIV_W-1:0] absB, rawA, rem, quot, diff;
  logic [DIV_W:0] remSh;
  logic negQ, negR, bZero, ge;
  assign remSh = {rem, quot[DIV_W-1]};
  assign ge = remSh >= {1'b0, absB};
  // the true difference is below absB, so the low DIV_W bits are exact
  assign diff = remSh[DIV_W-1:0] - absB;
  always_ff @(posedge clk)
    if (!rst) begin
      absB <= '0;
      rawA <= '0;
      rem <= '0;
      quot <= '0;
      negQ <= 1'b0;
      negR <= 1'b0;
      bZero <= 1'b0;
    end else if (load) begin
      absB <= (signedOp && b[DIV_W-1]) ? -b : b;
      quot <= (signedOp && a[DIV_W-1]) ? -a : a;
      rem <= '0;
      rawA <= a;
      negQ <= signedOp & (a[DIV_W-1] ^ b[DIV_W-1]);
      negR <= signedOp & a[DIV_W-1];
      bZero <= b == '0;
    end else if (step) begin
      rem <= ge ? diff : remSh[DIV_W-1:0];
      quot <= {quot[DIV_W-2:0], ge};
    end
  assign hiRes = !fix ? '0 : bZero ? rawA : negR ? -rem : rem;
  assign loRes = !fix ? '0 : bZero ? DIV_W'(DIV_ZERO_QUOT) : negQ ? -quot : quot;
endmodule

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: HI/LO register file with iterative divider and pipeline stall.
// Define HILO_BYPASS_EN to make hi_o/lo_o write-through.
module hilo_div_unit
  import hilo_pkg::*;
#(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start_i,
  input  logic             div_signed_i,
  input  logic [DIV_W-1:0] div_a_i,
  input  logic [DIV_W-1:0] div_b_i,
  input  logic             div_cancel_i,
  input  logic             hilo_we_i,
  input  logic             hilo_sel_i,
  input  logic [DIV_W-1:0] hilo_wdata_i,
  input  logic             mul_we_i,
  input  logic [DIV_W-1:0] mul_hi_i,
  input  logic [DIV_W-1:0] mul_lo_i,
  output logic             stall_o,
  output logic             div_done_o,
  output logic [DIV_W-1:0] hi_o,
  output logic [DIV_W-1:0] lo_o
);
  localparam int CNT_W = $clog2(DIV_ITER);
  divState_t state, stateNext;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] hiReg, loReg, hiNext, loNext, divHi, divLo;
  logic load, step, fix, divWe;
  div_core #(.DIV_W(DIV_W)) core (
    .clk(clk), .rst(rst), .load(load), .step(step), .fix(fix),
    .signedOp(div_signed_i), .a(div_a_i), .b(div_b_i),
    .hiRes(divHi), .loRes(divLo)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      hiReg <= '0;
      loReg <= '0;
    end else begin
      state <= stateNext;
      cnt <= load ? '0 : step ? cnt + CNT_W'(1) : cnt;
      hiReg <= hiNext;
      loReg <= loNext;
    end
  always_comb begin
    stateNext = state;
    load = 1'b0;
    step = 1'b0;
    fix = 1'b0;
    case (state)
      IDLE: begin
        load = div_start_i & !div_cancel_i;
        stateNext = load ? RUN : IDLE;
      end
      RUN: begin
        step = 1'b1;
        stateNext = div_cancel_i ? IDLE : (cnt == CNT_W'(DIV_ITER - 1)) ? FIX : RUN;
      end
      FIX: begin
        fix = 1'b1;
        stateNext = div_cancel_i ? IDLE : DONE;
      end
      default: stateNext = IDLE;
    endcase
  end
  // divider beats the older write-back instruction, product beats mthi/mtlo
  assign divWe = fix & !div_cancel_i;
  assign hiNext = divWe ? divHi : mul_we_i ? mul_hi_i : (hilo_we_i && hilo_sel_i) ? hilo_wdata_i : hiReg;
  assign loNext = divWe ? divLo : mul_we_i ? mul_lo_i : (hilo_we_i && !hilo_sel_i) ? hilo_wdata_i : loReg;
  assign stall_o = load | (state == RUN) | (state == FIX);
  assign div_done_o = state == DONE;
`ifdef HILO_BYPASS_EN
  assign hi_o = hiNext;
  assign lo_o = loNext;
`else
  assign hi_o = hiReg;
  assign lo_o = loReg;
`endif
endmodule

// File: tb/tb_hilo_div_unit.sv
// tb_hilo_div_unit: randomized self-checking bench for hilo_div_unit against an arithmetic reference.
module tb_hilo_div_unit;
  logic clk = 1'b0;
  logic rst;
  logic div_start_i, div_signed_i, div_cancel_i;
  logic [31:0] div_a_i, div_b_i;
  logic hilo_we_i, hilo_sel_i, mul_we_i;
  logic [31:0] hilo_wdata_i, mul_hi_i, mul_lo_i;
  logic stall_o, div_done_o;
  logic [31:0] hi_o, lo_o;
  int nChecks = 0;
  int nFails = 0;

  hilo_div_unit #(.DIV_W(32)) dut (
    .clk(clk), .rst(rst),
    .div_start_i(div_start_i), .div_signed_i(div_signed_i),
    .div_a_i(div_a_i), .div_b_i(div_b_i), .div_cancel_i(div_cancel_i),
    .hilo_we_i(hilo_we_i), .hilo_sel_i(hilo_sel_i), .hilo_wdata_i(hilo_wdata_i),
    .mul_we_i(mul_we_i), .mul_hi_i(mul_hi_i), .mul_lo_i(mul_lo_i),
    .stall_o(stall_o), .div_done_o(div_done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void refDiv(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (!sg) begin
      lo = a / b;
      hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000;
      hi = 0;
    end else begin
      lo = sa / sb;
      hi = sa % sb;
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the current cycle (entered at posedge+1); start is held like a stalled execute stage.
  task automatic runDiv(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input int weCyc, input int cancelCyc, input int rstCyc, input bit b2b);
    logic [31:0] eh, el, oldHi, oldLo;
    int stallCnt, doneAt, abortAt;
    refDiv(sg, a, b, eh, el);
    oldHi = hi_o;
    oldLo = lo_o;
    stallCnt = 0;
    doneAt = -1;
    abortAt = -1;
    div_signed_i = sg;
    div_a_i = a;
    div_b_i = b;
    div_start_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      hilo_we_i = (c == weCyc);
      hilo_sel_i = 1'b1;
      hilo_wdata_i = 32'hAAAA_0000;
      div_cancel_i = (c == cancelCyc);
      rst = (c != rstCyc);
      if (c == abortAt) div_start_i = 1'b0;
      #1;
      if (stall_o) stallCnt++;
      if (div_done_o) begin
        doneAt = c;
        break;
      end
      if (c == abortAt) break;
      if (c == cancelCyc || c == rstCyc) abortAt = c + 1;
      tick();
    end
    hilo_we_i = 1'b0;
    if (abortAt < 0) begin
      check("done_cycle", 32'(doneAt), 34);
      check("stall_cycles", 32'(stallCnt), 34);
      check("div_hi", hi_o, eh);
      check("div_lo", lo_o, el);
      if (b2b) tick();
      else begin
        div_start_i = 1'b0;
        tick();
        check("post_done", {31'b0, div_done_o}, 0);
        check("post_stall", {31'b0, stall_o}, 0);
      end
    end else begin
      check("abort_no_done", 32'(doneAt), 32'hFFFF_FFFF);
      check("abort_stall", {31'b0, stall_o}, 0);
      check("abort_hi", hi_o, (rstCyc >= 0) ? 32'h0 : oldHi);
      check("abort_lo", lo_o, (rstCyc >= 0) ? 32'h0 : oldLo);
      tick();
      check("abort_idle_done", {31'b0, div_done_o}, 0);
    end
  endtask

  initial begin
    logic [31:0] ph, pl, ra, rb;
    rst = 1'b0;
    div_start_i = 0; div_signed_i = 0; div_a_i = 0; div_b_i = 0; div_cancel_i = 0;
    hilo_we_i = 0; hilo_sel_i = 0; hilo_wdata_i = 0;
    mul_we_i = 0; mul_hi_i = 0; mul_lo_i = 0;
    repeat (3) tick();
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_stall", {31'b0, stall_o}, 0);
    check("rst_done", {31'b0, div_done_o}, 0);
    rst = 1'b1;
    tick();
    runDiv(0, 100, 7, -1, -1, -1, 0);
    runDiv(1, -32'sd7, 2, -1, -1, -1, 0);
    runDiv(1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1, 0);
    runDiv(0, 32'h1234_5678, 0, -1, -1, -1, 0);
    runDiv(1, 32'hF000_0001, 0, -1, -1, -1, 0);
    runDiv(1, 1000, 3, -1, 10, -1, 0);
    runDiv(0, 1000, 7, 33, -1, -1, 0);
    hilo_we_i = 1; hilo_sel_i = 0; hilo_wdata_i = 32'h55;
    tick();
    hilo_we_i = 0;
    check("mtlo_lo", lo_o, 32'h55);
    check("mtlo_hi", hi_o, 6);
    hilo_we_i = 1; hilo_sel_i = 1; hilo_wdata_i = 32'h0BAD_F00D;
    tick();
    hilo_we_i = 0;
    check("mthi_hi", hi_o, 32'h0BAD_F00D);
    check("mthi_lo", lo_o, 32'h55);
    ph = $urandom | 1; pl = $urandom | 1;
    mul_we_i = 1; mul_hi_i = ph; mul_lo_i = pl;
    hilo_we_i = 1; hilo_sel_i = 1; hilo_wdata_i = 32'h1111_2222;
    tick();
    mul_we_i = 0; hilo_we_i = 0;
    check("mul_hi", hi_o, ph);
    check("mul_lo", lo_o, pl);
    runDiv(1, $urandom, $urandom_range(1, 1000), -1, -1, 20, 0);
    runDiv(0, $urandom, $urandom_range(1, 99), -1, -1, -1, 0);
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom_range(1, 50);
        1: rb = -($urandom_range(1, 50));
        2: rb = $urandom;
        default: rb = (i == 11) ? 32'h0 : $urandom >> $urandom_range(0, 31);
      endcase
      runDiv(logic'($urandom_range(0, 1)), ra, rb, -1, -1, -1, i < 11);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
